// File: rtl/mymem_arb_pkg.sv
// Shared defaults and helpers for the mymem arbiter slice.
//   NREQ_DEF / AW_DEF / DW_DEF : default requester count, address width, data width
//   id_width()                 : requester index width (at least one bit)
package mymem_arb_pkg;

    localparam int unsigned NREQ_DEF = 2;
    localparam int unsigned AW_DEF   = 10;
    localparam int unsigned DW_DEF   = 64;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mymem_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or above rr_ptr (wrapping).
//   clock, reset : rising-edge clock, synchronous active-low reset
//   req          : request vector
//   advance      : a grant was taken this cycle; move rr_ptr past the winner
//   grant_c      : one-hot grant (combinational)
//   grant_idx_c  : index of the granted requester (combinational)
module rr_arbiter
    import mymem_arb_pkg::*;
#(
    parameter  int unsigned NREQ = NREQ_DEF,
    localparam int unsigned IDW  = id_width(NREQ)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant_c,
    output logic [IDW-1:0]  grant_idx_c
);

    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] rr_ptr_d;
    int unsigned    idx;
    logic           found;

    // Rotating priority search starting at rr_ptr
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        idx         = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NREQ;
            if (!found && req[IDW'(idx)]) begin
                found                = 1'b1;
                grant_c[IDW'(idx)]   = 1'b1;
                grant_idx_c          = IDW'(idx);
            end
        end
    end

    // Pointer moves to the requester after the winner, modulo NREQ
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance) begin
            rr_ptr_d = (grant_idx_c == IDW'(NREQ - 1)) ? '0 : grant_idx_c + IDW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/mymem_arbiter.sv
// Shares one single-port synchronous memory (1-cycle read latency) between NREQ requesters.
// Every request, read or write, gets one response word returned through a 1-entry slot.
//   clock, reset            : rising-edge clock, synchronous active-low reset
//   req_valid/ready/wren    : per-requester request handshake (req_ready is one-hot or zero)
//   req_addr, req_wrdata    : packed per-requester fields, requester i at [i*W +: W]
//   resp_valid/ready/data   : per-requester response slot (write returns pre-write contents)
//   mem_*                   : direct drive of / return from the memory port
//   idle                    : nothing in flight and all response slots empty
module mymem_arbiter
    import mymem_arb_pkg::*;
#(
    parameter  int unsigned NREQ = NREQ_DEF,
    parameter  int unsigned AW   = AW_DEF,
    parameter  int unsigned DW   = DW_DEF,
    localparam int unsigned IDW  = id_width(NREQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_wren,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wrdata,
    output logic [NREQ-1:0]    resp_valid,
    input  logic [NREQ-1:0]    resp_ready,
    output logic [NREQ*DW-1:0] resp_data,
    output logic               mem_rqvalid,
    output logic               mem_wren,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wrdata,
    input  logic               mem_rdvalid,
    input  logic [DW-1:0]      mem_rddata,
    output logic               idle
);

    logic [NREQ-1:0]    elig;
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     grant_idx;
    logic               grant_any;
    logic [NREQ-1:0]    inflight_oh;

    logic               inflight_vld_q, inflight_vld_d;
    logic [IDW-1:0]     inflight_id_q,  inflight_id_d;
    logic [NREQ-1:0]    resp_valid_q,   resp_valid_d;
    logic [NREQ*DW-1:0] resp_data_q,    resp_data_d;
    logic [AW-1:0]      addr_hold_q,    addr_hold_d;
    logic [DW-1:0]      wrdata_hold_q,  wrdata_hold_d;

    // A requester with a response pending (in flight or parked in its slot) may not issue again
    always_comb begin
        inflight_oh = '0;
        if (inflight_vld_q) begin
            inflight_oh[inflight_id_q] = 1'b1;
        end
    end

    // Reset gates eligibility so nothing reaches the memory while reset is low
    assign elig = req_valid & ~resp_valid_q & ~inflight_oh & {NREQ{reset}};

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clock       (clock),
        .reset       (reset),
        .req         (elig),
        .advance     (grant_any),
        .grant_c     (grant),
        .grant_idx_c (grant_idx)
    );

    assign grant_any = |grant;
    assign req_ready = grant;

    // Memory port mux; address and write data hold their last granted values when idle
    always_comb begin
        addr_hold_d   = addr_hold_q;
        wrdata_hold_d = wrdata_hold_q;
        if (grant_any) begin
            addr_hold_d   = req_addr[32'(grant_idx)*AW +: AW];
            wrdata_hold_d = req_wrdata[32'(grant_idx)*DW +: DW];
        end
        mem_rqvalid = grant_any;
        mem_wren    = grant_any & req_wren[grant_idx];
        mem_addr    = addr_hold_d;
        mem_wrdata  = wrdata_hold_d;
    end

    // In-flight tracking and response slots; a returning slot is always empty beforehand
    always_comb begin
        inflight_vld_d = grant_any;
        inflight_id_d  = grant_idx;
        resp_valid_d   = resp_valid_q & ~resp_ready;
        resp_data_d    = resp_data_q;
        if (mem_rdvalid && inflight_vld_q) begin
            resp_valid_d[inflight_id_q]                  = 1'b1;
            resp_data_d[32'(inflight_id_q)*DW +: DW]     = mem_rddata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            inflight_vld_q <= 1'b0;
            inflight_id_q  <= '0;
            resp_valid_q   <= '0;
            resp_data_q    <= '0;
            addr_hold_q    <= '0;
            wrdata_hold_q  <= '0;
        end else begin
            inflight_vld_q <= inflight_vld_d;
            inflight_id_q  <= inflight_id_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            addr_hold_q    <= addr_hold_d;
            wrdata_hold_q  <= wrdata_hold_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign idle       = ~inflight_vld_q & ~|resp_valid_q;

endmodule
